// File: rtl/mt_inst_decoder_pipe.sv
// Pipelined instruction decoder for the barrel core: one valid/ready output stage, HALT tracking per thread.
// Optional per-thread forwarded-instruction counters are built when DEC_INST_CNT_EN is defined.
module mt_inst_decoder_pipe #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int INST_ADDR_WIDTH    = 9,
    parameter int NUM_THREADS        = 4,
    parameter int THREAD_BITS        = 2,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          inst_valid_in,
    output logic                          inst_ready_out,
    input  logic [31:0]                   inst_in,
    input  logic [THREAD_BITS-1:0]        thread_id_in,
    input  logic                          dec_ready_in,
    output logic                          dec_valid_out,
    output logic [THREAD_BITS-1:0]        thread_id_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] r1_addr_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] r2_addr_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] wr_addr_out,
    output logic [DATAPATH_WIDTH-1:0]     imm_out,
    output logic [INST_ADDR_WIDTH-1:0]    branch_offset,
    output logic [3:0]                    alu_ctrl_out,
    output logic                          wr_en_out,
    output logic                          beq_out,
    output logic                          bneq_out,
    output logic                          imm_sel_out,
    output logic                          mem_write_out,
    output logic                          mem_reg_sel,
    input  logic [NUM_THREADS-1:0]        done_clr_in,
    output logic [NUM_THREADS-1:0]        thread_done,
    output logic                          all_done
`ifdef DEC_INST_CNT_EN
    ,
    output logic [NUM_THREADS*CNT_WIDTH-1:0] inst_cnt_out
`endif
);

    logic [5:0]             opcode;
    logic                   accept;
    logic                   is_halt;
    logic                   tid_legal;
    logic                   tid_done;
    logic                   forward;
    logic [3:0]             alu_next;
    logic [NUM_THREADS-1:0] tid_match;

    assign opcode         = inst_in[31:26];
    assign inst_ready_out = !dec_valid_out || dec_ready_in;
    assign accept         = inst_valid_in && inst_ready_out;
    assign is_halt        = (opcode == 6'b111111);
    assign tid_legal      = ({{(32-THREAD_BITS){1'b0}}, thread_id_in} < 32'(NUM_THREADS));
    assign forward        = accept && !is_halt && tid_legal && !tid_done;
    assign all_done       = &thread_done;

    // One-hot thread select; out-of-range ids match nothing, so they never touch per-thread state.
    always_comb begin
        tid_match = '0;
        tid_done  = 1'b0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (thread_id_in == THREAD_BITS'(t)) begin
                tid_match[t] = 1'b1;
                tid_done     = thread_done[t];
            end
        end
    end

    always_comb begin
        alu_next = inst_in[3:0];
        if (opcode[2]) begin
            alu_next = 4'd1;
        end else if (opcode[4] || opcode[3]) begin
            alu_next = 4'd2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_valid_out <= 1'b0;
            thread_id_out <= '0;
            r1_addr_out   <= '0;
            r2_addr_out   <= '0;
            wr_addr_out   <= '0;
            imm_out       <= '0;
            branch_offset <= '0;
            alu_ctrl_out  <= '0;
            wr_en_out     <= 1'b0;
            beq_out       <= 1'b0;
            bneq_out      <= 1'b0;
            imm_sel_out   <= 1'b0;
            mem_write_out <= 1'b0;
            mem_reg_sel   <= 1'b0;
        end else if (accept) begin
            // Dropped words clear valid but leave the bundle registers at their last value.
            dec_valid_out <= forward;
            if (forward) begin
                thread_id_out <= thread_id_in;
                r1_addr_out   <= inst_in[21 +: REGFILE_ADDR_WIDTH];
                r2_addr_out   <= inst_in[16 +: REGFILE_ADDR_WIDTH];
                wr_addr_out   <= inst_in[11 +: REGFILE_ADDR_WIDTH];
                imm_out       <= {{(DATAPATH_WIDTH-16){inst_in[15]}}, inst_in[15:0]};
                branch_offset <= inst_in[INST_ADDR_WIDTH-1:0];
                alu_ctrl_out  <= alu_next;
                wr_en_out     <= opcode[5];
                beq_out       <= opcode[4];
                bneq_out      <= opcode[3];
                imm_sel_out   <= opcode[2];
                mem_write_out <= opcode[1];
                mem_reg_sel   <= opcode[0];
            end
        end else if (dec_ready_in) begin
            dec_valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thread_done <= '0;
        end else begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                if (accept && is_halt && tid_match[t]) begin
                    thread_done[t] <= 1'b1;
                end else if (done_clr_in[t]) begin
                    thread_done[t] <= 1'b0;
                end
            end
        end
    end

`ifdef DEC_INST_CNT_EN
    logic [CNT_WIDTH-1:0] inst_cnt [NUM_THREADS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                inst_cnt[t] <= '0;
            end
        end else begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                if (done_clr_in[t]) begin
                    inst_cnt[t] <= '0;
                end else if (forward && tid_match[t] && (inst_cnt[t] != '1)) begin
                    inst_cnt[t] <= inst_cnt[t] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        inst_cnt_out = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            inst_cnt_out[t*CNT_WIDTH +: CNT_WIDTH] = inst_cnt[t];
        end
    end
`endif

endmodule
